// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and time validation for the alarm_bank slice.
package alarm_pkg;

   typedef enum logic [1:0] {
      SLOT_DISABLED = 2'd0,
      SLOT_ARMED    = 2'd1,
      SLOT_RINGING  = 2'd2,
      SLOT_SNOOZED  = 2'd3
   } slot_state_t;

   localparam logic [3:0] MAX_MS_HR      = 4'd2;
   localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
   localparam logic [3:0] MAX_MS_MIN     = 4'd5;
   localparam logic [3:0] MAX_DIGIT      = 4'd9;

   typedef struct packed {
      logic [3:0] ms_hr;
      logic [3:0] ls_hr;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } bcd_time_t;

   // True when t is a legal 24-hour hh:mm value (00:00 .. 23:59).
   function automatic logic bcd_time_valid(input bcd_time_t t);
      logic hr_ok;
      logic min_ok;
      if (t.ms_hr == MAX_MS_HR) hr_ok = (t.ls_hr <= MAX_LS_HR_AT_2);
      else                      hr_ok = (t.ms_hr < MAX_MS_HR) && (t.ls_hr <= MAX_DIGIT);
      min_ok = (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_DIGIT);
      return hr_ok && min_ok;
   endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: time/enable storage, minute comparator, ring/snooze FSM.
// ALARM_SNOOZE_EN adds the SNOOZED state and its counter.
module alarm_slot
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN   = 5,
   parameter int RING_MAX_MIN = 3
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      write,
   input  bcd_time_t write_time,
   input  logic      write_enable,
   input  bcd_time_t now,
   input  logic      minute_tick,
   input  logic      stop_alarm,
   input  logic      snooze,
   output bcd_time_t stored_time,
   output logic      stored_enable,
   output logic      ringing
);

   localparam logic [3:0] RING_LOAD = 4'(RING_MAX_MIN);

   slot_state_t state, state_next;
   logic [3:0]  ring_cnt, ring_cnt_next;

`ifdef ALARM_SNOOZE_EN
   localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MIN);
   logic [3:0] snz_cnt, snz_cnt_next;
`else
   logic unused_snooze;
   assign unused_snooze = snooze | (SNOOZE_MIN == 0);
`endif

   // NOTE: the stored time is reset along with the FSM so read-back shows 00:00 after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stored_time   <= '0;
         stored_enable <= 1'b0;
      end else if (write) begin
         stored_time   <= write_time;
         stored_enable <= write_enable;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= SLOT_DISABLED;
         ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt  <= '0;
`endif
      end else begin
         state    <= state_next;
         ring_cnt <= ring_cnt_next;
`ifdef ALARM_SNOOZE_EN
         snz_cnt  <= snz_cnt_next;
`endif
      end
   end

   // Priority: write > stop > snooze > minute-tick transitions.
   always_comb begin
      state_next    = state;
      ring_cnt_next = ring_cnt;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_next  = snz_cnt;
`endif
      if (write) begin
         state_next    = write_enable ? SLOT_ARMED : SLOT_DISABLED;
         ring_cnt_next = '0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt_next  = '0;
`endif
      end else if (stop_alarm) begin
         if (state == SLOT_RINGING || state == SLOT_SNOOZED) state_next = SLOT_ARMED;
`ifdef ALARM_SNOOZE_EN
      end else if (snooze && state == SLOT_RINGING) begin
         state_next   = SLOT_SNOOZED;
         snz_cnt_next = SNOOZE_LOAD;
`endif
      end else if (minute_tick) begin
         case (state)
            SLOT_ARMED: begin
               if (stored_time == now) begin
                  state_next    = SLOT_RINGING;
                  ring_cnt_next = RING_LOAD;
               end
            end
            SLOT_RINGING: begin
               if (ring_cnt <= 4'd1) begin
                  state_next    = SLOT_ARMED;
                  ring_cnt_next = '0;
               end else begin
                  ring_cnt_next = ring_cnt - 4'd1;
               end
            end
`ifdef ALARM_SNOOZE_EN
            SLOT_SNOOZED: begin
               if (snz_cnt <= 4'd1) begin
                  state_next    = SLOT_RINGING;
                  ring_cnt_next = RING_LOAD;
                  snz_cnt_next  = '0;
               end else begin
                  snz_cnt_next = snz_cnt - 4'd1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign ringing = (state == SLOT_RINGING);

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot BCD alarm bank: write validation, ack/err pulses, registered read-back.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_bank
   import alarm_pkg::*;
#(
   parameter  int NUM_ALARMS   = 4,
   parameter  int SNOOZE_MIN   = 5,
   parameter  int RING_MAX_MIN = 3,
   localparam int IDX_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_new_alarm,
   input  logic [IDX_W-1:0]      load_idx,
   input  logic                  load_enable,
   input  logic [3:0]            new_alarm_ms_hr,
   input  logic [3:0]            new_alarm_ls_hr,
   input  logic [3:0]            new_alarm_ms_min,
   input  logic [3:0]            new_alarm_ls_min,
   output logic                  load_ack,
   output logic                  load_err,
   input  logic [3:0]            current_time_ms_hr,
   input  logic [3:0]            current_time_ls_hr,
   input  logic [3:0]            current_time_ms_min,
   input  logic [3:0]            current_time_ls_min,
   input  logic                  minute_tick,
   input  logic                  stop_alarm,
   input  logic                  snooze,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [3:0]            alarm_time_ms_hr,
   output logic [3:0]            alarm_time_ls_hr,
   output logic [3:0]            alarm_time_ms_min,
   output logic [3:0]            alarm_time_ls_min,
   output logic                  rd_enable,
   output logic [NUM_ALARMS-1:0] alarm_active,
   output logic                  alarm_sound
);

   bcd_time_t             write_time;
   bcd_time_t             now;
   bcd_time_t             slot_time [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] slot_en;
   logic [NUM_ALARMS-1:0] slot_write;
   logic [NUM_ALARMS-1:0] slot_ring;
   logic                  write_ok;
   bcd_time_t             rd_time, rd_time_next;
   logic                  rd_en_next;

   assign write_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
   assign now        = {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};
   assign write_ok   = load_new_alarm && (int'(load_idx) < NUM_ALARMS) && bcd_time_valid(write_time);

   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
      assign slot_write[g] = write_ok && (load_idx == IDX_W'(g));

      alarm_slot #(
         .SNOOZE_MIN   (SNOOZE_MIN),
         .RING_MAX_MIN (RING_MAX_MIN)
      ) u_slot (
         .clock         (clock),
         .reset         (reset),
         .write         (slot_write[g]),
         .write_time    (write_time),
         .write_enable  (load_enable),
         .now           (now),
         .minute_tick   (minute_tick),
         .stop_alarm    (stop_alarm),
         .snooze        (snooze),
         .stored_time   (slot_time[g]),
         .stored_enable (slot_en[g]),
         .ringing       (slot_ring[g])
      );
   end

   // Out-of-range read indices return zero rather than an undefined slot.
   always_comb begin
      rd_time_next = '0;
      rd_en_next   = 1'b0;
      if (int'(rd_idx) < NUM_ALARMS) begin
         rd_time_next = slot_time[rd_idx];
         rd_en_next   = slot_en[rd_idx];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         load_ack  <= 1'b0;
         load_err  <= 1'b0;
         rd_time   <= '0;
         rd_enable <= 1'b0;
      end else begin
         load_ack  <= write_ok;
         load_err  <= load_new_alarm && !write_ok;
         rd_time   <= rd_time_next;
         rd_enable <= rd_en_next;
      end
   end

   assign alarm_time_ms_hr  = rd_time.ms_hr;
   assign alarm_time_ls_hr  = rd_time.ls_hr;
   assign alarm_time_ms_min = rd_time.ms_min;
   assign alarm_time_ls_min = rd_time.ls_min;
   assign alarm_active      = slot_ring;
   assign alarm_sound       = |slot_ring;

endmodule
